// File: rtl/stereo_pkg.sv
// stereo_pkg: geometry defaults and FSM encoding shared by the line buffer and the disparity engine
package stereo_pkg;
  localparam int DEF_WIN = 15;
  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 64;
  localparam int DEF_DISP_BITS = 6;
  typedef enum logic [2:0] {FILL, START, WAIT, EMIT, CLEAR, LOAD} state_t;
endpackage

// File: rtl/stereo_band_store.sv
// stereo_band_store: staging row plus WIN-row band; a shift pushes the staging row in as the newest row
module stereo_band_store #(
  parameter int WIN = 3,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en_i,
  input  logic [$clog2(IMG_W)-1:0]       wr_col_i,
  input  logic [DATA_SIZE-1:0]           wr_data_i,
  input  logic                           shift_i,
  output logic [DATA_SIZE*IMG_W*WIN-1:0] band_o
);
  localparam int ROW_BITS = DATA_SIZE * IMG_W;
  logic [ROW_BITS-1:0] stage_q, stage_d;
  logic [ROW_BITS*WIN-1:0] band_q;
  always_comb begin
    stage_d = stage_q;
    if (wr_en_i) stage_d[wr_col_i*DATA_SIZE +: DATA_SIZE] = wr_data_i;
  end
  // row 0 sits in the low bits, so dropping the oldest row is a right shift by one row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      band_q <= '0;
    end else begin
      stage_q <= stage_d;
      if (shift_i) band_q <= {stage_d, band_q[ROW_BITS*WIN-1:ROW_BITS]};
    end
  end
  assign band_o = band_q;
endmodule

// File: rtl/stereo_line_buffer.sv
// stereo_line_buffer: buffers a WIN-row stereo band and sweeps the disparity engine across it column by column
module stereo_line_buffer import stereo_pkg::*; #(
  parameter int WIN = DEF_WIN,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int NUM_COLS = IMG_W - WIN + 1,
  parameter int IMG_W_ARR = 6,
  parameter int DISP_BITS = DEF_DISP_BITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [DATA_SIZE-1:0]           pix_L,
  input  logic [DATA_SIZE-1:0]           pix_R,
  output logic [DATA_SIZE*IMG_W*WIN-1:0] input_array_L,
  output logic [DATA_SIZE*IMG_W*WIN-1:0] input_array_R,
  output logic [IMG_W_ARR-1:0]           col_index,
  output logic                           eng_start,
  output logic                           eng_rst,
  input  logic                           eng_done,
  input  logic [DISP_BITS-1:0]           eng_disp,
  output logic [DISP_BITS-1:0]           disp_out,
  output logic                           disp_valid,
  input  logic                           disp_ready,
  output logic                           frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 1);
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [IMG_W_ARR-1:0] cidx_q, cidx_d;
  logic [DISP_BITS-1:0] disp_q, disp_d;
  logic pix_ready_q, eng_start_q, eng_rst_q, disp_valid_q, frame_done_q, frame_done_d;
  logic acc, row_done, last_col;
  assign acc = pix_valid && pix_ready_q;
  assign row_done = acc && col_q == CW'(IMG_W - 1);
  assign last_col = cidx_q == IMG_W_ARR'(NUM_COLS - 1);
  always_comb begin
    state_d = state_q;
    cidx_d = cidx_q;
    disp_d = disp_q;
    frame_done_d = 1'b0;
    col_d = row_done ? '0 : acc ? col_q + 1'b1 : col_q;
    row_d = row_done ? row_q + 1'b1 : row_q;
    case (state_q)
      FILL: if (row_done && row_q == RW'(WIN - 1)) begin
        state_d = START;
        cidx_d = '0;
      end
      START: state_d = WAIT;
      WAIT: if (eng_done) begin
        disp_d = eng_disp;
        state_d = EMIT;
      end
      EMIT: if (disp_ready) state_d = CLEAR;
      CLEAR: begin
        cidx_d = last_col ? '0 : cidx_q + 1'b1;
        state_d = !last_col ? START : row_q == RW'(IMG_H) ? FILL : LOAD;
        if (last_col && row_q == RW'(IMG_H)) begin
          row_d = '0;
          frame_done_d = 1'b1;
        end
      end
      LOAD: if (row_done) state_d = START;
      default: state_d = FILL;
    endcase
  end
  // control outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      col_q <= '0;
      row_q <= '0;
      cidx_q <= '0;
      disp_q <= '0;
      pix_ready_q <= 1'b0;
      eng_start_q <= 1'b0;
      eng_rst_q <= 1'b1;
      disp_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      cidx_q <= cidx_d;
      disp_q <= disp_d;
      pix_ready_q <= state_d == FILL || state_d == LOAD;
      eng_start_q <= state_d == START;
      eng_rst_q <= state_d == CLEAR;
      disp_valid_q <= state_d == EMIT;
      frame_done_q <= frame_done_d;
    end
  end
  stereo_band_store #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W)) u_band_l (
    .clk(clk), .rst(rst), .wr_en_i(acc), .wr_col_i(col_q), .wr_data_i(pix_L),
    .shift_i(row_done), .band_o(input_array_L)
  );
  stereo_band_store #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W)) u_band_r (
    .clk(clk), .rst(rst), .wr_en_i(acc), .wr_col_i(col_q), .wr_data_i(pix_R),
    .shift_i(row_done), .band_o(input_array_R)
  );
  assign pix_ready = pix_ready_q;
  assign col_index = cidx_q;
  assign eng_start = eng_start_q;
  assign eng_rst = eng_rst_q;
  assign disp_out = disp_q;
  assign disp_valid = disp_valid_q;
  assign frame_done = frame_done_q;
endmodule
